mem_burst_scheduler: RTL
========================

Name: mem_burst_scheduler

Overview:
- Parametrised round-robin burst scheduler that replaces the fixed 8-port arbitration in the cell-RAM path.
- Serves NUM_CH write channels (FIFO->RAM, e.g. EP2/ADC tracking FIFOs) and NUM_CH read channels (RAM->FIFO, e.g. DAC/EP6 tracking FIFOs).
- Channel c owns a ring-buffer region in RAM. The block keeps per-channel RAM write/read pointers and issues one fixed-length burst command at a time to the memory datapath.
- The datapath executes each burst and pulses completion back to the block.

Parameters:
- NUM_CH, 4, channel pairs; must be a power of 2, 1..16.
- CH_W, 2, log2(NUM_CH); minimum 1.
- LEVEL_W, 12, width of each FIFO level/space field.
- REGION_AW, 21, log2 of words per channel region.
- BURST, 16, words per burst; power of 2, ≤ 2^REGION_AW.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- wr_level  in  NUM_CH*LEVEL_W  words available in write-channel FIFO c, at bits [c*LEVEL_W +: LEVEL_W].
- rd_space  in  NUM_CH*LEVEL_W  free words in read-channel FIFO c.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  datapath accepts the command.
- cmd_dir  out  1  0 = FIFO->RAM (write), 1 = RAM->FIFO (read).
- cmd_ch  out  CH_W  channel index.
- cmd_addr  out  CH_W+REGION_AW  RAM word address = {ch, pointer}.
- cmd_len  out  REGION_AW+1  burst length in words.
- cmd_done  in  1  one-cycle pulse: current burst finished.
- ram_fill  out  NUM_CH*(REGION_AW+1)  per-channel RAM occupancy.
- busy  out  1  high in ISSUE or WAIT.

Behaviour:
- Reset (reset low at a rising edge): all pointers 0, state IDLE, round-robin pointer 0.
  - Outputs: cmd_valid 0, cmd_dir 0, cmd_ch 0, cmd_addr 0, cmd_len 0, busy 0, ram_fill 0.
  - Reset mid-burst abandons the burst; a late cmd_done is ignored.
- Per-channel state:
  - wp[c], rp[c] are REGION_AW+1 bits; the extra bit is the wrap bit.
  - fill[c] = wp[c]-rp[c], mod 2^(REGION_AW+1).
  - Region full when fill = 2^REGION_AW.
- 2*NUM_CH requestors, index r:
  - r < NUM_CH: write channel r. Eligible when wr_level ≥ BURST and 2^REGION_AW - fill ≥ BURST.
  - r ≥ NUM_CH: read channel r-NUM_CH. Eligible when fill ≥ BURST and rd_space ≥ BURST.
- States:
  - IDLE: evaluate eligibility combinationally from registered pointers and current inputs. Pick the first eligible r starting at rr_ptr, wrapping modulo 2*NUM_CH. If found, register the command fields, set rr_ptr = r+1 (mod 2*NUM_CH), and go to ISSUE next cycle. If none, stay in IDLE.
  - ISSUE: cmd_valid=1. Fields stay stable until the cycle cmd_ready=1; then go to WAIT.
  - WAIT: hold fields, cmd_valid=0. On cmd_done:
    - write burst: wp[ch] += cmd_len.
    - read burst: rp[ch] += cmd_len.
    - Return to IDLE.
- Latency:
  - Minimum 1 cycle from eligibility to cmd_valid.
  - Minimum 3 cycles between successive cmd_valid assertions, assuming cmd_ready and cmd_done each arrive 1 cycle later.
- Addresses:
  - cmd_addr = {ch, ptr[REGION_AW-1:0]}, where ptr is wp[ch] (write) or rp[ch] (read).
  - Bursts never straddle a region end, because BURST divides 2^REGION_AW and pointers only advance by BURST.
- Edge cases:
  - cmd_done in IDLE or ISSUE is ignored.
  - cmd_ready and cmd_done high in the same ISSUE cycle: only the handshake counts.
  - Pointer wrap: the wrap bit toggles; fill remains correct across the wrap.
- Input trust: wr_level and rd_space are trusted as given. The datapath must transfer exactly cmd_len words.
- ram_fill is registered and updates the cycle after each pointer change.

Optional Feature:
- Macro: MEM_SCHED_PARTIAL_FLUSH_EN.
- When defined, adds port flush_req (in, NUM_CH): per-channel request to drain partial data.
- If a channel is not eligible for a full burst but flush_req[c]=1, its requestors become flush-eligible:
  - write side: len = min(wr_level, free space).
  - read side: len = min(fill, rd_space).
  - Either length must be nonzero.
- Flush-eligible requestors are scanned only when no full-burst requestor is eligible. Round-robin order is the same.
- A partial burst must not cross the region end: len is further clipped to 2^REGION_AW - ptr[REGION_AW-1:0].
- Pointers advance by the actual len.
- When the macro is undefined: no flush_req port, and cmd_len is always BURST.

Test Plan:
1. Reset held low 3 cycles while wr_level[0]=100 → cmd_valid, busy and ram_fill stay 0; the first command appears 1 cycle after reset goes high, with ch 0, dir 0, addr 0, len 16.
2. wr_level[0]=32, datapath auto-acks, cmd_done issued 4 cycles after each handshake → two write bursts at addr 0x000000 and 0x000010; ram_fill[0]=32.
3. All four write channels at level 16, with two write bursts already done per channel → grants rotate ch0, ch1, ch2, ch3; then, with rd_space=64 everywhere, reads rotate ch0 through ch3.
4. Small-region case, REGION_AW=5 with 2 bursts per region: fill to full, so a write is not granted with wr_level=50; drain once with a read, rewrite, and check that cmd_addr wraps to base {ch,0} and the wrap bit makes ram_fill=32.
5. cmd_ready held low 10 cycles → cmd_valid and all fields remain stable; a stray cmd_done during ISSUE is ignored, and pointers change only after a cmd_done in WAIT.
6. With MEM_SCHED_PARTIAL_FLUSH_EN: wr_level[2]=5 and flush_req[2]=1 → a write burst with len 5; then a read is granted on fill=5 with rd_space≥5, giving len 5 and ram_fill[2]=0.

Source files
------------

// File: rtl/mem_burst_scheduler.sv
// mem_burst_scheduler: round-robin burst scheduler for the cell-RAM path.
// Serves NUM_CH write channels (FIFO->RAM) and NUM_CH read channels (RAM->FIFO),
// each owning a ring-buffer region, and issues one burst command at a time.
// Optional feature macro: MEM_SCHED_PARTIAL_FLUSH_EN (adds flush_req and
// variable-length partial bursts; when undefined cmd_len is always BURST).
module mem_burst_scheduler #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned LEVEL_W   = 12,
    parameter int unsigned REGION_AW = 21,
    parameter int unsigned BURST     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH*LEVEL_W-1:0]        wr_level,
    input  logic [NUM_CH*LEVEL_W-1:0]        rd_space,
`ifdef MEM_SCHED_PARTIAL_FLUSH_EN
    input  logic [NUM_CH-1:0]                flush_req,
`endif
    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic                             cmd_dir,
    output logic [CH_W-1:0]                  cmd_ch,
    output logic [CH_W+REGION_AW-1:0]        cmd_addr,
    output logic [REGION_AW:0]               cmd_len,
    input  logic                             cmd_done,
    output logic [NUM_CH*(REGION_AW+1)-1:0]  ram_fill,
    output logic                             busy
);

    localparam int unsigned PW   = REGION_AW + 1;
    localparam int unsigned NR   = 2 * NUM_CH;
    localparam int unsigned RR_W = $clog2(NR);
    localparam int unsigned CW   = (LEVEL_W > PW) ? LEVEL_W : PW;

    localparam logic [PW-1:0] REGION_WORDS = {1'b1, {REGION_AW{1'b0}}};
    localparam logic [PW-1:0] BURST_LEN    = PW'(BURST);
    localparam logic [CW-1:0] BURST_CW     = CW'(BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]   wp_q [NUM_CH];
    logic [PW-1:0]   rp_q [NUM_CH];
    logic [PW-1:0]   fill [NUM_CH];
    logic [PW-1:0]   free [NUM_CH];
    logic [CW-1:0]   lvl_e [NUM_CH];
    logic [CW-1:0]   spc_e [NUM_CH];
    logic [NR-1:0]   elig_full;
    logic [RR_W-1:0] rr_q;

    logic                 found;
    logic [RR_W-1:0]      pick;
    logic [RR_W-1:0]      scan_idx;
    logic                 pick_dir;
    logic [CH_W-1:0]      pick_ch;
    logic [REGION_AW-1:0] pick_lo;
    logic [PW-1:0]        pick_len;
    logic                 grant;
    logic                 done_acc;

`ifdef MEM_SCHED_PARTIAL_FLUSH_EN
    logic [NR-1:0]   elig_flush;
    logic [PW-1:0]   req_len [NR];
    logic            use_flush;

    function automatic logic [CW-1:0] min_cw(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction
`endif

    // Per-channel occupancy and full-burst eligibility of every requestor
    always_comb begin
        elig_full = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            fill[c]  = wp_q[c] - rp_q[c];
            free[c]  = REGION_WORDS - fill[c];
            lvl_e[c] = CW'(wr_level[c*LEVEL_W +: LEVEL_W]);
            spc_e[c] = CW'(rd_space[c*LEVEL_W +: LEVEL_W]);
            elig_full[c]        = (lvl_e[c] >= BURST_CW) && (CW'(free[c]) >= BURST_CW);
            elig_full[NUM_CH+c] = (CW'(fill[c]) >= BURST_CW) && (spc_e[c] >= BURST_CW);
        end
    end

`ifdef MEM_SCHED_PARTIAL_FLUSH_EN
    // Partial-burst lengths, clipped so a burst never crosses the region end
    always_comb begin
        elig_flush = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            req_len[c] = PW'(min_cw(min_cw(lvl_e[c], CW'(free[c])),
                         CW'(REGION_WORDS - PW'(wp_q[c][REGION_AW-1:0]))));
            req_len[NUM_CH+c] = PW'(min_cw(min_cw(CW'(fill[c]), spc_e[c]),
                         CW'(REGION_WORDS - PW'(rp_q[c][REGION_AW-1:0]))));
            elig_flush[c]        = !elig_full[c] && flush_req[c] && (req_len[c] != '0);
            elig_flush[NUM_CH+c] = !elig_full[NUM_CH+c] && flush_req[c]
                                   && (req_len[NUM_CH+c] != '0);
        end
    end
`endif

    // Round-robin scan from rr_q; partial bursts only when no full burst is possible
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = '0;
`ifdef MEM_SCHED_PARTIAL_FLUSH_EN
        use_flush = 1'b0;
`endif
        for (int unsigned i = 0; i < NR; i++) begin
            scan_idx = rr_q + RR_W'(i);
            if (!found && elig_full[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
`ifdef MEM_SCHED_PARTIAL_FLUSH_EN
        for (int unsigned i = 0; i < NR; i++) begin
            scan_idx = rr_q + RR_W'(i);
            if (!found && !use_flush && elig_flush[scan_idx]) begin
                use_flush = 1'b1;
                pick      = scan_idx;
            end
        end
        found = found || use_flush;
`endif
    end

    // Command fields of the selected requestor
    always_comb begin
        pick_dir = (pick >= RR_W'(NUM_CH));
        pick_ch  = CH_W'(pick % RR_W'(NUM_CH));
        pick_lo  = pick_dir ? rp_q[pick_ch][REGION_AW-1:0] : wp_q[pick_ch][REGION_AW-1:0];
`ifdef MEM_SCHED_PARTIAL_FLUSH_EN
        pick_len = use_flush ? req_len[pick] : BURST_LEN;
`else
        pick_len = BURST_LEN;
`endif
    end

    // Next-state logic: IDLE picks, ISSUE waits for handshake, WAIT waits for done
    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        done_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_ISSUE;
                    grant   = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmd_done) begin
                    state_d  = ST_IDLE;
                    done_acc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with registered valid/busy decoded from the next state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_valid <= (state_d == ST_ISSUE);
            busy      <= (state_d != ST_IDLE);
        end
    end

    // Capture command fields and advance the round-robin pointer on a grant
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q     <= '0;
            cmd_dir  <= 1'b0;
            cmd_ch   <= '0;
            cmd_addr <= '0;
            cmd_len  <= '0;
        end else if (grant) begin
            rr_q     <= pick + RR_W'(1);
            cmd_dir  <= pick_dir;
            cmd_ch   <= pick_ch;
            cmd_addr <= {pick_ch, pick_lo};
            cmd_len  <= pick_len;
        end
    end

    // Ring pointers advance only when the outstanding burst completes
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                wp_q[c] <= '0;
                rp_q[c] <= '0;
            end
        end else if (done_acc) begin
            if (cmd_dir) begin
                rp_q[cmd_ch] <= rp_q[cmd_ch] + cmd_len;
            end else begin
                wp_q[cmd_ch] <= wp_q[cmd_ch] + cmd_len;
            end
        end
    end

    // Registered occupancy, one cycle behind the pointers
    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_fill <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                ram_fill[c*PW +: PW] <= fill[c];
            end
        end
    end

endmodule
